// File: rtl/axilite4_reg_slave_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Holds channel FSM encodings, response codes and register index map.
package axilite4_reg_slave_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned NUM_RW   = 14;
    localparam int unsigned WIN_LSB  = 6;

    localparam logic [IDX_W-1:0]  IDX_COUNTER = 4'd14;
    localparam logic [IDX_W-1:0]  IDX_ID      = 4'd15;
    localparam logic [DATA_W-1:0] RESP_OKAY   = 32'h0000_0000;
    localparam logic [DATA_W-1:0] RESP_SLVERR = 32'h0000_0002;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rdState_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wrState_t;

    // Write port payload into the register bank.
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } regWrite_t;

    function automatic logic isWritable(input logic [IDX_W-1:0] idx);
        return idx < IDX_COUNTER;
    endfunction

endpackage

// File: rtl/axilite4_reg_bank.sv
// Register storage for the AXI4-Lite slave: 14 RW words, a free-running
// cycle counter and a constant ID word, with a combinational read port.
module axilite4_reg_bank
    import axilite4_reg_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic [DATA_W-1:0] rdData_c,
    input  logic              wrEn,
    input  regWrite_t         wrReq
);

    logic [DATA_W-1:0] regs [NUM_RW];
    logic [DATA_W-1:0] cycleCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[wrReq.idx] <= wrReq.data;
        end
    end

    // Wraps naturally at 32'hFFFF_FFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycleCount <= '0;
        end else begin
            cycleCount <= cycleCount + 32'd1;
        end
    end

    always_comb begin
        rdData_c = '0;
        if (rdIdx == IDX_COUNTER) begin
            rdData_c = cycleCount;
        end else if (rdIdx == IDX_ID) begin
            rdData_c = ID_VALUE;
        end else begin
            rdData_c = regs[rdIdx];
        end
    end

endmodule

// File: rtl/axilite4_reg_slave.sv
// AXI4-Lite register slave: independent read and write channel FSMs plus
// address decode in front of a 16-word register bank.
module axilite4_reg_slave
    import axilite4_reg_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'hA11E_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] readAddr_addr,
    input  logic              readAddr_valid,
    output logic              readAddr_ready,
    output logic [DATA_W-1:0] readData_data,
    output logic              readData_valid,
    input  logic              readData_ready,
    input  logic [ADDR_W-1:0] writeAddr_addr,
    input  logic              writeAddr_valid,
    output logic              writeAddr_ready,
    input  logic [DATA_W-1:0] writeData_data,
    input  logic              writeData_valid,
    output logic              writeData_ready,
    output logic [DATA_W-1:0] writeResp_msg,
    output logic              writeResp_valid,
    input  logic              writeResp_ready
);

    rdState_t          rdState, rdNext;
    wrState_t          wrState, wrNext;
    logic [DATA_W-1:0] rdDataNext, respMsgNext, bankRdData;
    logic              rdValidNext, respValidNext;
    logic              rdInRange, wrInRange, wrAccept, wrCommit;
    logic [IDX_W-1:0]  rdIdx, wrIdx;
    regWrite_t         bankWrReq;
    logic              unusedAddrBits;

    assign rdIdx     = readAddr_addr[WIN_LSB-1:2];
    assign wrIdx     = writeAddr_addr[WIN_LSB-1:2];
    assign rdInRange = (readAddr_addr[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB]);
    assign wrInRange = (writeAddr_addr[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB]);
    assign unusedAddrBits = ^{readAddr_addr[1:0], writeAddr_addr[1:0]};

    // Address and data are only ever accepted together.
    assign wrAccept = (wrState == W_IDLE) && writeAddr_valid && writeData_valid;
    assign wrCommit = wrAccept && wrInRange && isWritable(wrIdx);

    assign readAddr_ready  = (rdState == R_IDLE);
    assign writeAddr_ready = wrAccept;
    assign writeData_ready = wrAccept;

    assign bankWrReq = '{idx: wrIdx, data: writeData_data};

    axilite4_reg_bank #(
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (rdIdx),
        .rdData_c (bankRdData),
        .wrEn     (wrCommit),
        .wrReq    (bankWrReq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdState         <= R_IDLE;
            readData_data   <= '0;
            readData_valid  <= 1'b0;
            wrState         <= W_IDLE;
            writeResp_msg   <= '0;
            writeResp_valid <= 1'b0;
        end else begin
            rdState         <= rdNext;
            readData_data   <= rdDataNext;
            readData_valid  <= rdValidNext;
            wrState         <= wrNext;
            writeResp_msg   <= respMsgNext;
            writeResp_valid <= respValidNext;
        end
    end

    // Read channel: bank is sampled at the handshake edge, so a same-cycle
    // write to the same index is seen only by later reads.
    always_comb begin
        rdNext      = rdState;
        rdDataNext  = readData_data;
        rdValidNext = readData_valid;
        case (rdState)
            R_IDLE: begin
                if (readAddr_valid) begin
                    rdNext      = R_RESP;
                    rdDataNext  = rdInRange ? bankRdData : '0;
                    rdValidNext = 1'b1;
                end
            end
            R_RESP: begin
                if (readData_ready) begin
                    rdNext      = R_IDLE;
                    rdValidNext = 1'b0;
                end
            end
        endcase
    end

    // Write channel.
    always_comb begin
        wrNext        = wrState;
        respMsgNext   = writeResp_msg;
        respValidNext = writeResp_valid;
        case (wrState)
            W_IDLE: begin
                if (wrAccept) begin
                    wrNext        = W_RESP;
                    respMsgNext   = wrCommit ? RESP_OKAY : RESP_SLVERR;
                    respValidNext = 1'b1;
                end
            end
            W_RESP: begin
                if (writeResp_ready) begin
                    wrNext        = W_IDLE;
                    respValidNext = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_axilite4_reg_slave.sv
// Scoreboard bench for axilite4_reg_slave: queued requests, reference model
// of the register map, and an independent response monitor.
module tb_axilite4_reg_slave;

    localparam logic [31:0] TB_BASE = 32'h0000_0000;
    localparam logic [31:0] TB_ID   = 32'hA11E_0001;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } tbWr_t;

    logic        clk, rst;
    logic [31:0] readAddr_addr, readData_data, writeAddr_addr, writeData_data, writeResp_msg;
    logic        readAddr_valid, readAddr_ready, readData_valid, readData_ready;
    logic        writeAddr_valid, writeAddr_ready, writeData_valid, writeData_ready;
    logic        writeResp_valid, writeResp_ready;

    axilite4_reg_slave #(
        .BASE_ADDR (TB_BASE),
        .ID_VALUE  (TB_ID)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .readAddr_addr   (readAddr_addr),
        .readAddr_valid  (readAddr_valid),
        .readAddr_ready  (readAddr_ready),
        .readData_data   (readData_data),
        .readData_valid  (readData_valid),
        .readData_ready  (readData_ready),
        .writeAddr_addr  (writeAddr_addr),
        .writeAddr_valid (writeAddr_valid),
        .writeAddr_ready (writeAddr_ready),
        .writeData_data  (writeData_data),
        .writeData_valid (writeData_valid),
        .writeData_ready (writeData_ready),
        .writeResp_msg   (writeResp_msg),
        .writeResp_valid (writeResp_valid),
        .writeResp_ready (writeResp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] modelMem [16];
    logic [31:0] modelCnt;
    logic [31:0] rdReqQ [$];
    tbWr_t       wrReqQ [$];
    logic [31:0] expRdQ [$];
    logic [31:0] expWrQ [$];
    bit          randomMode = 0;
    int          rdHold = 0;
    int          wrHold = 0;

    // Cycles elapsed since reset released; this is what register 14 shows.
    always @(posedge clk or posedge rst) begin
        if (rst) modelCnt <= 32'd0;
        else     modelCnt <= modelCnt + 32'd1;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (!ok) begin
            nErrors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [3:0] idx = a[5:2];
        if (a[31:6] != TB_BASE[31:6]) return 32'h0;
        if (idx == 4'd14) return modelCnt;
        if (idx == 4'd15) return TB_ID;
        return modelMem[idx];
    endfunction

    function automatic logic [31:0] modelWrite(input logic [31:0] a, input logic [31:0] d);
        logic [3:0] idx = a[5:2];
        if (a[31:6] != TB_BASE[31:6] || idx >= 4'd14) return 32'h2;
        modelMem[idx] = d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] randAddr();
        logic [25:0] up = TB_BASE[31:6];
        if ($urandom % 8 == 0) up = up ^ 26'($urandom_range(1, 4095));
        return {up, 4'($urandom % 16), 2'($urandom)};
    endfunction

    // Driver: presents queued requests, records expectations at accept time.
    initial begin
        bit    rdHs, wrHs, wrPartial;
        tbWr_t w;
        wrPartial = 0;
        readAddr_valid = 0; readAddr_addr = '0; readData_ready = 1;
        writeAddr_valid = 0; writeData_valid = 0; writeAddr_addr = '0;
        writeData_data = '0; writeResp_ready = 1;
        forever begin
            @(negedge clk);
            rdHs = !rst && readAddr_valid && readAddr_ready;
            wrHs = !rst && writeAddr_valid && writeData_valid && writeAddr_ready;
            if (rdHs) expRdQ.push_back(modelRead(readAddr_addr));
            if (wrHs) expWrQ.push_back(modelWrite(writeAddr_addr, writeData_data));
            @(posedge clk);
            #1;
            if (rst) begin
                readAddr_valid = 0; writeAddr_valid = 0; writeData_valid = 0; wrPartial = 0;
            end else begin
                if (rdHs) readAddr_valid = 0;
                if (wrHs) begin writeAddr_valid = 0; writeData_valid = 0; end
                if (!readAddr_valid && rdReqQ.size() > 0) begin
                    readAddr_addr  = rdReqQ.pop_front();
                    readAddr_valid = 1;
                end
                if (wrPartial) begin
                    writeData_valid = 1;
                    wrPartial = 0;
                end else if (!writeAddr_valid && wrReqQ.size() > 0) begin
                    w = wrReqQ.pop_front();
                    writeAddr_addr  = w.addr;
                    writeData_data  = w.data;
                    writeAddr_valid = 1;
                    if (randomMode && $urandom % 4 == 0) wrPartial = 1;
                    else writeData_valid = 1;
                end
                readData_ready  = (rdHold > 0) ? 1'b0 : (randomMode ? ($urandom % 4 != 0) : 1'b1);
                writeResp_ready = (wrHold > 0) ? 1'b0 : (randomMode ? ($urandom % 4 != 0) : 1'b1);
                if (rdHold > 0) rdHold--;
                if (wrHold > 0) wrHold--;
            end
        end
    end

    // Monitor: compares responses against the scoreboard and checks protocol.
    initial begin
        bit          expValid, afterRdHs, stallPrev;
        logic [31:0] prevData, e;
        expValid = 0; afterRdHs = 0; stallPrev = 0; prevData = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expValid = 0; afterRdHs = 0; stallPrev = 0;
            end else begin
                if (expValid) check(readData_valid === 1'b1, "rd_latency", 32'(readData_valid), 32'd1);
                expValid = readAddr_valid && readAddr_ready;
                if (afterRdHs) check(!readData_valid && readAddr_ready, "rd_back_to_idle",
                                     {readData_valid, readAddr_ready}, 32'd1);
                afterRdHs = 0;
                if (readData_valid) begin
                    check(readAddr_ready === 1'b0, "rd_addr_ready_busy", 32'(readAddr_ready), 32'd0);
                    if (stallPrev) check(readData_data === prevData, "rd_data_stable", readData_data, prevData);
                    if (readData_ready) begin
                        if (expRdQ.size() == 0) check(0, "rd_unexpected", readData_data, 32'hx);
                        else begin
                            e = expRdQ.pop_front();
                            check(readData_data === e, "rd_data", readData_data, e);
                        end
                        afterRdHs = 1; stallPrev = 0;
                    end else begin
                        stallPrev = 1; prevData = readData_data;
                    end
                end else stallPrev = 0;
                if (writeAddr_valid != writeData_valid)
                    check(!writeAddr_ready && !writeData_ready, "wr_split_not_accepted",
                          {writeAddr_ready, writeData_ready}, 32'd0);
                if (writeResp_valid) begin
                    check(writeAddr_ready === 1'b0, "wr_ready_busy", 32'(writeAddr_ready), 32'd0);
                    if (writeResp_ready) begin
                        if (expWrQ.size() == 0) check(0, "wr_unexpected", writeResp_msg, 32'hx);
                        else begin
                            e = expWrQ.pop_front();
                            check(writeResp_msg === e, "wr_resp", writeResp_msg, e);
                        end
                    end
                end
            end
        end
    end

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdReqQ.size() == 0 && wrReqQ.size() == 0 && expRdQ.size() == 0 && expWrQ.size() == 0 &&
                !readAddr_valid && !writeAddr_valid && !writeData_valid &&
                !readData_valid && !writeResp_valid) return;
        end
        check(0, {"idle_timeout_", tag}, 32'(expRdQ.size()), 32'(expWrQ.size()));
    endtask

    task automatic pushWr(input logic [31:0] a, input logic [31:0] d);
        tbWr_t w;
        w.addr = a; w.data = d;
        wrReqQ.push_back(w);
    endtask

    task automatic readAll();
        for (int i = 0; i < 16; i++) rdReqQ.push_back(TB_BASE + 32'(i * 4));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit sawResp;
        for (int i = 0; i < 16; i++) modelMem[i] = 32'h0;
        rst = 1;
        repeat (3) @(posedge clk);
        #3;
        check(readAddr_ready === 1'b1, "rst_rd_addr_ready", 32'(readAddr_ready), 32'd1);
        check(readData_valid === 1'b0, "rst_rd_valid", 32'(readData_valid), 32'd0);
        check(readData_data === 32'h0, "rst_rd_data", readData_data, 32'h0);
        check(writeResp_valid === 1'b0, "rst_wr_valid", 32'(writeResp_valid), 32'd0);
        check(writeResp_msg === 32'h0, "rst_wr_msg", writeResp_msg, 32'h0);
        check(writeAddr_ready === 1'b0 && writeData_ready === 1'b0, "rst_wr_ready",
              {writeAddr_ready, writeData_ready}, 32'd0);
        @(posedge clk); #2 rst = 0;

        pushWr(TB_BASE + 32'h08, 32'h1234_5678); waitIdle("w08");
        rdReqQ.push_back(TB_BASE + 32'h08);      waitIdle("r08");

        rdReqQ.push_back(TB_BASE + 32'h3C); pushWr(TB_BASE + 32'h3C, 32'hDEAD_BEEF); waitIdle("id");
        rdReqQ.push_back(TB_BASE + 32'h3C); pushWr(TB_BASE + 32'h38, 32'h1111_2222); waitIdle("id2");
        rdReqQ.push_back(TB_BASE + 32'h38); waitIdle("cnt");

        rdReqQ.push_back(32'h0000_1000); pushWr(32'h0000_1000, 32'hCAFE_F00D); waitIdle("oor");
        readAll(); waitIdle("oor_all");

        rdHold = 8; rdReqQ.push_back(TB_BASE + 32'h08); waitIdle("stall");

        pushWr(TB_BASE + 32'h0C, 32'hAAAA_AAAA); waitIdle("r3a");
        pushWr(TB_BASE + 32'h0C, 32'h5555_5555); rdReqQ.push_back(TB_BASE + 32'h0C); waitIdle("rbw");
        rdReqQ.push_back(TB_BASE + 32'h0C); waitIdle("r3b");

        randomMode = 1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #3;
            if (rdReqQ.size() < 2 && $urandom % 3 == 0) rdReqQ.push_back(randAddr());
            if (wrReqQ.size() < 2 && $urandom % 3 == 0) pushWr(randAddr(), $urandom);
        end
        randomMode = 0;
        waitIdle("random");
        readAll(); waitIdle("random_all");

        // Reset while a write response is pending.
        wrHold = 100;
        pushWr(TB_BASE + 32'h14, 32'h0BAD_0BAD);
        sawResp = 0;
        for (int i = 0; i < 50 && !sawResp; i++) begin
            @(negedge clk);
            sawResp = writeResp_valid;
        end
        check(sawResp, "wr_resp_pending", 32'(sawResp), 32'd1);
        @(posedge clk); #2 rst = 1;
        #1;
        check(writeResp_valid === 1'b0, "rst_mid_wr_valid", 32'(writeResp_valid), 32'd0);
        expRdQ.delete(); expWrQ.delete(); rdReqQ.delete(); wrReqQ.delete();
        for (int i = 0; i < 16; i++) modelMem[i] = 32'h0;
        wrHold = 0; rdHold = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        readAll(); waitIdle("post_rst_all");

        check(expRdQ.size() == 0 && expWrQ.size() == 0, "scoreboard_drained",
              32'(expRdQ.size()), 32'(expWrQ.size()));
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
